spi_timing_gen: RTL and testbench
=================================

Name: spi_timing_gen

Overview:
Timing and counting core of the SPI master, running entirely in the 100 MHz system clock domain. It integrates three functions:
- an SCLK divider (100 MHz to 5 MHz, 50 % duty) with single-cycle edge strobes;
- a bit/byte transfer counter advanced on SCLK rising strobes;
- a slow display-refresh divider for the 7-segment multiplexer.

The FSM, PISO/SIPO shifters and display logic consume its outputs.

Parameters:
- SCLK_HALF, 10, system-clock cycles per SCLK half period (100 MHz/(2*10) = 5 MHz); legal range ≥1.
- DISP_HALF, 50000, system-clock cycles per display_clk half period (1 kHz); legal range ≥1.
- BYTE_W, 2, byte counter width.

Ports:
- clk, input, 1, 100 MHz system clock.
- rst, input, 1, reset, asynchronous, active-high.
- cnt_clr, input, 1, synchronous clear of bit/byte counters.
- cnt_en, input, 1, counting enable (transfer/receive active).
- sclk, output, 1, registered SPI serial clock.
- sclk_rise, output, 1, one-clk pulse coincident with sclk 0→1.
- sclk_fall, output, 1, one-clk pulse coincident with sclk 1→0.
- bit_cnt, output, 3, bit index within current byte.
- byte_cnt, output, BYTE_W, completed-byte count.
- byte_done, output, 1, one-clk pulse when bit_cnt wraps 7→0.
- display_clk, output, 1, registered display refresh square wave.
- disp_tick, output, 1, one-clk pulse coincident with display_clk 0→1.

Behaviour:
- One clock is used throughout. Reset is asynchronous and active-high. All outputs are registered.
- Reset values: sclk=0, display_clk=0, all pulses=0, bit_cnt=0, byte_cnt=0, internal dividers=0. Assertion mid-operation forces these values immediately.

SCLK divider:
- div_cnt counts 0..SCLK_HALF-1.
- On reaching SCLK_HALF-1: div_cnt←0 and sclk toggles. Otherwise div_cnt increments.
- sclk_rise/sclk_fall are registered in the same edge as the toggle, so they are high exactly during the first clk cycle of the new sclk level.
- After reset release, the first sclk rise occurs at the SCLK_HALF-th clk edge. Period is 2*SCLK_HALF clk cycles; high and low each last SCLK_HALF cycles.
- SCLK_HALF=1: sclk toggles every clk, and rise and fall strobes alternate.

Counter:
- Updates only on a clk edge where sclk_rise=1 is registered, i.e. it acts in the cycle that sclk_rise is high, with the result visible next cycle.
- Priority: rst > cnt_clr > cnt_en.
- cnt_clr=1 (any cycle, regardless of sclk_rise): bit_cnt←0, byte_cnt←0, byte_done←0.
- cnt_en=1 and sclk_rise=1: bit_cnt increments.
- When bit_cnt==7 in that case: bit_cnt←0, byte_cnt increments modulo 2^BYTE_W (3→0 wraps), and byte_done pulses one cycle.
- cnt_en=0: counts hold.
- The divider free-runs independent of cnt_en/cnt_clr.

Display divider:
- Same structure as the SCLK divider, using DISP_HALF. disp_tick is high one cycle per display_clk period.

Other rules:
- No combinational paths from inputs to outputs.

Decomposition:
- Shared package spi_pkg holds CLK_HZ=100_000_000, SCLK_HZ=5_000_000, default SCLK_HALF/DISP_HALF and the byte-count typedef (logic [1:0]).
- One natural sub-module, tick_div: a parameterised half-period divider producing a square wave plus rise/fall strobes. It is instantiated twice (SCLK and display). The counter stays inline.

Test Plan:
1. Reset then free-run 200 clk → first sclk rise at edge 10; period 20 clk; 10 high/10 low; exactly one sclk_rise and one sclk_fall per period.
2. cnt_en=1 for 8 sclk_rise → bit_cnt 0..7 then 0, byte_cnt=1, byte_done high exactly one clk; after 32 rises byte_cnt wraps to 0.
3. cnt_en toggled low mid-byte at bit_cnt=4 → counts hold at 4 for 3 sclk periods, then resume at 5.
4. cnt_clr and cnt_en both high on an sclk_rise cycle with bit_cnt=5, byte_cnt=2 → next cycle both counts are 0 and no byte_done.
5. Assert rst asynchronously mid-sclk-high, between clk edges → sclk, display_clk, counts and strobes are 0 immediately; re-release gives first rise after 10 clk again.
6. DISP_HALF=4, SCLK_HALF=1 override → display_clk period 8 clk with disp_tick once per period; sclk toggles every clk with strobes alternating.

Source files
------------

// File: rtl/spi_timing_gen_pkg.sv
// Shared constants and types for the SPI master timing core.
package spi_pkg;

    localparam int CLK_HZ  = 100_000_000;
    localparam int SCLK_HZ = 5_000_000;

    localparam int SCLK_HALF_DEF = CLK_HZ / (2 * SCLK_HZ);
    localparam int DISP_HALF_DEF = 50_000;
    localparam int BYTE_W_DEF    = 2;

    typedef logic [BYTE_W_DEF-1:0] byte_cnt_t;

endpackage

// File: rtl/spi_timing_gen_tick_div.sv
// Half-period divider: square wave plus single-cycle rise/fall strobes that
// mark the first clk cycle of each new level.
module tick_div #(
    parameter int HALF = 10
) (
    input  logic clk,
    input  logic rst,
    output logic wave,
    output logic rise,
    output logic fall
);

    localparam int            CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;

    // NOTE: registers use non-blocking assignments so every one samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            wave <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else if (cnt == LAST) begin
            cnt  <= '0;
            wave <= ~wave;
            rise <= ~wave;
            fall <= wave;
        end else begin
            cnt  <= cnt + CW'(1);
            rise <= 1'b0;
            fall <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_timing_gen.sv
// SPI master timing core: SCLK divider, bit/byte transfer counter and
// display refresh divider, all in the system clock domain.
module spi_timing_gen
    import spi_pkg::*;
#(
    parameter int SCLK_HALF = SCLK_HALF_DEF,
    parameter int DISP_HALF = DISP_HALF_DEF,
    parameter int BYTE_W    = BYTE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cnt_clr,
    input  logic              cnt_en,
    output logic              sclk,
    output logic              sclk_rise,
    output logic              sclk_fall,
    output logic [2:0]        bit_cnt,
    output logic [BYTE_W-1:0] byte_cnt,
    output logic              byte_done,
    output logic              display_clk,
    output logic              disp_tick
);

    // The display multiplexer only needs the rising strobe.
    logic disp_fall_unused;

    tick_div #(.HALF(SCLK_HALF)) u_sclk_div (
        .clk  (clk),
        .rst  (rst),
        .wave (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    tick_div #(.HALF(DISP_HALF)) u_disp_div (
        .clk  (clk),
        .rst  (rst),
        .wave (display_clk),
        .rise (disp_tick),
        .fall (disp_fall_unused)
    );

    // Clear wins over counting; bit_cnt rolls 7 -> 0 by its own width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= 1'b0;
            if (cnt_clr) begin
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end else if (cnt_en && sclk_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_cnt  <= byte_cnt + BYTE_W'(1);
                    byte_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_timing_gen.sv
// Self-checking bench for spi_timing_gen: cycle scoreboard plus directed scenarios.
module tb_spi_timing_gen;
    import spi_pkg::*;

    localparam int SH  = 10;
    localparam int DH  = 64;
    localparam int SH2 = 1;
    localparam int DH2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, cnt_clr = 1'b0, cnt_en = 1'b0;
    logic       sclk, sclk_rise, sclk_fall, byte_done, display_clk, disp_tick;
    logic [2:0] bit_cnt;
    byte_cnt_t  byte_cnt;

    logic       rst2 = 1'b1, clr2 = 1'b0, en2 = 1'b0;
    logic       sclk2, rise2, fall2, done2, disp2, tick2;
    logic [2:0] bit2;
    byte_cnt_t  byte2;

    spi_timing_gen #(.SCLK_HALF(SH), .DISP_HALF(DH), .BYTE_W(2)) dut (
        .clk(clk), .rst(rst), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
        .sclk(sclk), .sclk_rise(sclk_rise), .sclk_fall(sclk_fall),
        .bit_cnt(bit_cnt), .byte_cnt(byte_cnt), .byte_done(byte_done),
        .display_clk(display_clk), .disp_tick(disp_tick)
    );

    spi_timing_gen #(.SCLK_HALF(SH2), .DISP_HALF(DH2), .BYTE_W(2)) dut_fast (
        .clk(clk), .rst(rst2), .cnt_clr(clr2), .cnt_en(en2),
        .sclk(sclk2), .sclk_rise(rise2), .sclk_fall(fall2),
        .bit_cnt(bit2), .byte_cnt(byte2), .byte_done(done2),
        .display_clk(disp2), .disp_tick(tick2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Expected square wave level / strobe after n clk edges since reset release.
    function automatic logic exp_wave(input int n, input int h);
        return ((n / h) % 2) == 1;
    endfunction

    function automatic logic exp_edge(input int n, input int h, input logic lvl);
        return (n > 0) && (n % h == 0) && (exp_wave(n, h) == lvl);
    endfunction

    typedef struct packed {
        logic      sclk;
        logic      rise;
        logic      fall;
        logic [2:0] bitc;
        byte_cnt_t bytec;
        logic      done;
        logic      disp;
        logic      tick;
    } exp_t;

    exp_t       sb[$];
    int         n_m    = 0;
    logic [2:0] bit_m  = '0;
    byte_cnt_t  byte_m = '0;
    logic       rise_m = 1'b0;

    // Reference model: produces the expected outputs for each clk edge.
    always @(posedge clk or posedge rst) begin
        exp_t e;
        if (rst) begin
            n_m    = 0;
            bit_m  = '0;
            byte_m = '0;
            rise_m = 1'b0;
            sb.delete();
        end else begin
            n_m++;
            e.done = 1'b0;
            if (cnt_clr) begin
                bit_m  = '0;
                byte_m = '0;
            end else if (cnt_en && rise_m) begin
                if (bit_m == 3'd7) begin
                    bit_m  = '0;
                    byte_m = byte_m + 2'd1;
                    e.done = 1'b1;
                end else begin
                    bit_m = bit_m + 3'd1;
                end
            end
            e.sclk  = exp_wave(n_m, SH);
            e.rise  = exp_edge(n_m, SH, 1'b1);
            e.fall  = exp_edge(n_m, SH, 1'b0);
            e.bitc  = bit_m;
            e.bytec = byte_m;
            e.disp  = exp_wave(n_m, DH);
            e.tick  = exp_edge(n_m, DH, 1'b1);
            rise_m  = e.rise;
            sb.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_sclk",      sclk,        e.sclk);
            check("sb_sclk_rise", sclk_rise,   e.rise);
            check("sb_sclk_fall", sclk_fall,   e.fall);
            check("sb_bit_cnt",   bit_cnt,     e.bitc);
            check("sb_byte_cnt",  byte_cnt,    e.bytec);
            check("sb_byte_done", byte_done,   e.done);
            check("sb_disp_clk",  display_clk, e.disp);
            check("sb_disp_tick", disp_tick,   e.tick);
        end
    end

    int rise_seen = 0;
    int done_seen = 0;

    task automatic step();
        @(posedge clk);
        #1;
        if (sclk_rise) rise_seen++;
        if (byte_done) done_seen++;
    endtask

    task automatic run_rises(input int k);
        int start;
        int budget;
        start  = rise_seen;
        budget = (k + 2) * 2 * SH;
        while ((rise_seen - start) < k && budget > 0) begin
            step();
            budget--;
        end
        if ((rise_seen - start) < k) check("rise_timeout", rise_seen - start, k);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_sclk"},      sclk,        0);
        check({pfx, "_sclk_rise"}, sclk_rise,   0);
        check({pfx, "_sclk_fall"}, sclk_fall,   0);
        check({pfx, "_bit_cnt"},   bit_cnt,     0);
        check({pfx, "_byte_cnt"},  byte_cnt,    0);
        check({pfx, "_byte_done"}, byte_done,   0);
        check({pfx, "_disp_clk"},  display_clk, 0);
        check({pfx, "_disp_tick"}, disp_tick,   0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_rise, rises, falls, highs, budget, ticks;

        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk) rst = 1'b0;

        // Free-run: first rise at edge 10, 10 high / 10 low per period.
        first_rise = -1; rises = 0; falls = 0; highs = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (sclk_rise) begin
                rises++;
                if (first_rise < 0) first_rise = i;
            end
            if (sclk_fall) falls++;
            if (sclk) highs++;
        end
        check("first_rise_edge", first_rise, SH);
        check("rise_count_200",  rises, 200 / (2 * SH));
        check("fall_count_200",  falls, 200 / (2 * SH));
        check("high_cycles_200", highs, 100);

        // One full byte, then wrap of the byte counter after 32 bits.
        @(negedge clk) cnt_en = 1'b1;
        rise_seen = 0; done_seen = 0;
        run_rises(8);
        step();
        check("byte1_bit_cnt",  bit_cnt, 0);
        check("byte1_byte_cnt", byte_cnt, 1);
        check("byte1_done_cnt", done_seen, 1);
        run_rises(24);
        step();
        check("wrap_byte_cnt",  byte_cnt, 0);
        check("wrap_bit_cnt",   bit_cnt, 0);
        check("wrap_done_cnt",  done_seen, 4);

        // Hold mid-byte with cnt_en low.
        budget = 400;
        while (bit_cnt != 3'd4 && budget > 0) begin step(); budget--; end
        check("reach_bit4", bit_cnt, 4);
        @(negedge clk) cnt_en = 1'b0;
        run_rises(3);
        step();
        check("hold_bit_cnt",  bit_cnt, 4);
        check("hold_byte_cnt", byte_cnt, 0);
        @(negedge clk) cnt_en = 1'b1;
        run_rises(1);
        step();
        check("resume_bit_cnt", bit_cnt, 5);

        // Clear and enable together on a rise cycle at bit 5, byte 2.
        @(negedge clk) cnt_clr = 1'b1;
        @(negedge clk) cnt_clr = 1'b0;
        budget = 2000;
        while (!(byte_cnt == 2'd2 && bit_cnt == 3'd5) && budget > 0) begin step(); budget--; end
        budget = 4 * SH;
        while (!sclk_rise && budget > 0) begin step(); budget--; end
        check("pre_clr_rise",     sclk_rise, 1);
        check("pre_clr_bit_cnt",  bit_cnt, 5);
        check("pre_clr_byte_cnt", byte_cnt, 2);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("clr_bit_cnt",   bit_cnt, 0);
        check("clr_byte_cnt",  byte_cnt, 0);
        check("clr_byte_done", byte_done, 0);

        // Asynchronous reset in the middle of an sclk-high phase.
        budget = 100;
        while (!(sclk && !sclk_rise && bit_cnt != 3'd0) && budget > 0) begin step(); budget--; end
        check("pre_rst_sclk_high", sclk, 1);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        first_rise = -1;
        for (int i = 1; i <= 3 * SH && first_rise < 0; i++) begin
            @(posedge clk);
            #1;
            if (sclk_rise) first_rise = i;
        end
        check("rerelease_first_rise", first_rise, SH);

        // Overridden instance: SCLK_HALF=1, DISP_HALF=4.
        @(negedge clk) rst2 = 1'b0;
        ticks = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            check("fast_sclk",      sclk2, exp_wave(n, SH2));
            check("fast_sclk_rise", rise2, exp_edge(n, SH2, 1'b1));
            check("fast_sclk_fall", fall2, exp_edge(n, SH2, 1'b0));
            check("fast_disp_clk",  disp2, exp_wave(n, DH2));
            check("fast_disp_tick", tick2, exp_edge(n, DH2, 1'b1));
            if (tick2) ticks++;
        end
        check("fast_tick_count", ticks, 40 / (2 * DH2));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
